// File: rtl/purifier_bank.sv
// Bank of independent debounce/glitch filters with confirm and fast modes.
// Define PURIFIER_GLITCHCNT_EN to build the saturating rejected-glitch counter.
module purifier_bank #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] mode,
    input  logic             clr_glitch,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [15:0]      glitch_cnt
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_syncPrev;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_cleanQ;
    logic [WIDTH-1:0] r_modeQ;
    state_t           r_state [WIDTH];
    logic [CW-1:0]    r_cnt   [WIDTH];

    state_t           w_stateNext [WIDTH];
    logic [CW-1:0]    w_cntNext   [WIDTH];
    logic [WIDTH-1:0] w_cleanNext;
    logic [WIDTH-1:0] w_glitch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= RESET_VAL;
            r_sync2    <= RESET_VAL;
            r_syncPrev <= RESET_VAL;
            r_clean    <= RESET_VAL;
            r_cleanQ   <= RESET_VAL;
            r_modeQ    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1    <= in;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
            r_clean    <= w_cleanNext;
            r_cleanQ   <= r_clean;
            r_modeQ    <= mode;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_stateNext[i];
                r_cnt[i]   <= w_cntNext[i];
            end
        end
    end

    // A mode change resets the channel's filter without touching its clean level.
    always_comb begin
        w_cleanNext = r_clean;
        w_glitch    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_stateNext[i] = r_state[i];
            w_cntNext[i]   = r_cnt[i];
            if (mode[i] != r_modeQ[i]) begin
                w_stateNext[i] = IDLE;
                w_cntNext[i]   = '0;
            end else if (r_state[i] == HOLD) begin
                if (r_cnt[i] == LAST) begin
                    w_cleanNext[i] = r_sync2[i];
                    w_stateNext[i] = IDLE;
                    w_cntNext[i]   = '0;
                end else if (r_sync2[i] == r_syncPrev[i]) begin
                    w_cntNext[i] = r_cnt[i] + 1'b1;
                end else begin
                    w_cntNext[i] = '0;
                end
            end else if (mode[i]) begin
                w_cntNext[i] = '0;
                if (r_sync2[i] != r_clean[i]) begin
                    w_cleanNext[i] = r_sync2[i];
                    w_stateNext[i] = HOLD;
                end
            end else begin
                if (r_sync2[i] == r_clean[i]) begin
                    w_glitch[i]  = (r_cnt[i] != '0);
                    w_cntNext[i] = '0;
                end else if (r_cnt[i] == LAST) begin
                    w_cleanNext[i] = r_sync2[i];
                    w_cntNext[i]   = '0;
                end else begin
                    w_cntNext[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign clean = r_clean;
    assign rise  = r_clean & ~r_cleanQ;
    assign fall  = ~r_clean & r_cleanQ;

`ifdef PURIFIER_GLITCHCNT_EN
    logic [15:0] r_glitchCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_glitchCnt <= '0;
        end else if (clr_glitch) begin
            r_glitchCnt <= '0;
        end else if ((|w_glitch) && (r_glitchCnt != 16'hFFFF)) begin
            r_glitchCnt <= r_glitchCnt + 16'd1;
        end
    end

    assign glitch_cnt = r_glitchCnt;
`else
    logic w_unused;

    assign w_unused   = ^{clr_glitch, w_glitch};
    assign glitch_cnt = 16'h0000;
`endif

endmodule

// File: doc/purifier_bank.md
PURIFIER_BANK -- requirements
Module: purifier_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent channels, 1..32.
REQ-002 SHALL have parameter DEPTH, default 8: consecutive stable samples needed to accept a level, 2..255.
REQ-003 SHALL have parameter RESET_VAL, default all zeros, [WIDTH-1:0]: clean level loaded at reset.
REQ-004 SHALL have port clk  input  1: single clock; all state on posedge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high.
REQ-006 SHALL have port in  input  WIDTH: raw asynchronous channel inputs.
REQ-007 SHALL have port mode  input  WIDTH: per-channel filter mode; 0 = confirm, 1 = fast.
REQ-008 SHALL have port clr_glitch  input  1: synchronous clear of glitch_cnt.
REQ-009 SHALL have port clean  output  WIDTH: filtered levels, registered.
REQ-010 SHALL have port rise  output  WIDTH: one-cycle pulse per channel on clean 0->1.
REQ-011 SHALL have port fall  output  WIDTH: one-cycle pulse per channel on clean 1->0.
REQ-012 SHALL have port glitch_cnt  output  16: rejected-glitch counter (see Configuration).

Function
REQ-013 SHALL pass each in bit through a 2-flop synchronizer; sync = second flop; filtering acts on sync only.
REQ-014 SHALL keep, per channel, a run counter of width clog2(DEPTH+1) and a 2-state FSM {IDLE, HOLD}.
REQ-015 Confirm mode, IDLE only: sync==clean -> counter <= 0; sync!=clean -> counter++; on the cycle counter==DEPTH-1 with sync!=clean -> clean <= sync, counter <= 0.
REQ-016 Confirm mode latency: clean changes exactly 2+DEPTH cycles after a clean input step.
REQ-017 Confirm mode glitch: counter nonzero and sync returns to clean before acceptance -> counter <= 0, clean unchanged, glitch event for that cycle.
REQ-018 Fast mode IDLE: sync!=clean -> clean <= sync, counter <= 0, state <= HOLD (latency 3 cycles from input step).
REQ-019 Fast mode HOLD: sync equal to previous sync -> counter++, else counter <= 0; clean frozen; on counter==DEPTH-1 -> clean <= sync, state <= IDLE.
REQ-020 SHALL drive rise = clean & ~clean_q and fall = ~clean & clean_q, clean_q being clean delayed one cycle; never both for one channel.
REQ-021 A change of mode[i] SHALL force channel i to IDLE with counter 0 on the next edge; clean[i] held, no pulse generated.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels all take effect in the same cycle.

Reset
REQ-023 Reset asserted SHALL immediately set sync flops, clean and clean_q to RESET_VAL, counters to 0, FSMs to IDLE, rise/fall to 0, glitch_cnt to 0.
REQ-024 Reset release SHALL produce no rise/fall pulse; filtering resumes on the first clk edge after release.
REQ-025 Reset mid-acceptance SHALL discard partial counts; no clean change follows from pre-reset samples.

Configuration
REQ-026 Macro PURIFIER_GLITCHCNT_EN defined: glitch_cnt increments by 1 on any cycle where at least one channel raises a glitch event (OR across channels), saturates at 16'hFFFF, clr_glitch zeroes it and wins over a same-cycle increment.
REQ-027 Macro PURIFIER_GLITCHCNT_EN undefined: glitch_cnt tied to 16'h0000, no counter logic; clr_glitch ignored.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=8'h00)
REQ-028 Reset with in=8'hFF, release, hold in -> clean=8'h00 until cycle 6 after release, then 8'hFF; rise=8'hFF for exactly one cycle; no pulse at release.
REQ-029 Confirm mode, in[0] pulses high for 3 cycles -> clean[0] stays 0, rise[0] never asserts, glitch_cnt=1 (macro on) / 0 (macro off).
REQ-030 mode[1]=1, in[1] steps 0->1 then toggles every cycle for 6 cycles, then stays 1 -> clean[1]=1 3 cycles after the step, no fall[1], clean[1]=1 after settling.
REQ-031 Glitches on channels 2 and 3 in the same cycle, then clr_glitch asserted coincident with a further glitch -> glitch_cnt reads 1 then 0.
REQ-032 Reset asserted 2 cycles into a 4-cycle acceptance on channel 4 -> all outputs return to reset values asynchronously; clean[4] needs a full 2+4 cycles after release.
REQ-033 glitch_cnt forced to saturate (65 540 glitches) -> holds 16'hFFFF, clr_glitch returns it to 0.
